// File: rtl/conv2d_window_mac_multich.sv
// Multi-channel 2D convolution window MAC.
// Each accepted beat carries one FILT_DIM x FILT_DIM window for the current
// channel. Products are registered (S1), summed into a wide accumulator (S2),
// and after N_CH beats the result gets bias, optional ReLU and saturation
// before it is presented on the output handshake.
module conv2d_window_mac_multich #(
    parameter int FILT_DIM  = 3,
    parameter int BIT_WIDTH = 16,
    parameter int NFRAC     = 10,
    parameter int N_CH      = 4,
    parameter int RELU_EN   = 1,
    localparam int K        = FILT_DIM * FILT_DIM,
    localparam int AW       = $clog2(N_CH * K + 1)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        cfg_we,
    input  logic [AW-1:0]               cfg_addr,
    input  logic signed [BIT_WIDTH-1:0] cfg_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [K*BIT_WIDTH-1:0]      in_window,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [BIT_WIDTH-1:0] out_data,
    output logic                        out_sat
);
    localparam int PW    = 2 * BIT_WIDTH;
    localparam int ACC_W = PW + $clog2(K * N_CH);
    localparam int RW    = ACC_W + 1;
    localparam int CW    = (N_CH > 1) ? $clog2(N_CH) : 1;

    localparam logic [CW-1:0] CH_LAST = CW'(N_CH - 1);

    localparam logic [1:0] ST_ACCUM = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_OUT   = 2'd2;

    // Saturation bounds expressed at finalise width.
    localparam logic signed [RW-1:0] SAT_MAX = {{(RW-BIT_WIDTH+1){1'b0}}, {(BIT_WIDTH-1){1'b1}}};
    localparam logic signed [RW-1:0] SAT_MIN = {{(RW-BIT_WIDTH+1){1'b1}}, {(BIT_WIDTH-1){1'b0}}};

    logic [1:0]                   state_q, state_d;
    logic [CW-1:0]                ch_cnt_q, ch_cnt_d;
    logic                         s1_valid_q, s1_valid_d;
    logic [K-1:0][PW-1:0]         prod_q, prod_d;
    logic signed [ACC_W-1:0]      acc_q, acc_d;
    logic                         out_valid_q, out_valid_d;
    logic signed [BIT_WIDTH-1:0]  out_data_q, out_data_d;
    logic                         out_sat_q, out_sat_d;
    logic signed [BIT_WIDTH-1:0]  weight_q [N_CH][K];
    logic signed [BIT_WIDTH-1:0]  weight_d [N_CH][K];
    logic signed [BIT_WIDTH-1:0]  bias_q, bias_d;

    logic                         accept;
    logic signed [ACC_W-1:0]      prod_sum;
    logic signed [RW-1:0]         fin_sum;
    logic signed [RW-1:0]         fin_relu;
    logic signed [BIT_WIDTH-1:0]  fin_data;
    logic                         fin_sat;

    assign in_ready  = (state_q == ST_ACCUM);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

    // S1: one multiplier per tap using the current channel's weight bank;
    // the product is floored back to NFRAC fractional bits before registering.
    genvar gi;
    generate
        for (gi = 0; gi < K; gi++) begin : g_tap
            logic signed [BIT_WIDTH-1:0] x_tap;
            logic signed [PW-1:0]        full_prod;
            logic signed [PW-1:0]        scaled_prod;
            assign x_tap       = $signed(in_window[gi*BIT_WIDTH +: BIT_WIDTH]);
            assign full_prod   = PW'(weight_q[ch_cnt_q][gi]) * PW'(x_tap);
            assign scaled_prod = full_prod >>> NFRAC;
            assign prod_d[gi]  = accept ? scaled_prod : prod_q[gi];
        end
    endgenerate

    // Config write decode; a beat in the same cycle still sees the old bank.
    always_comb begin
        weight_d = weight_q;
        bias_d   = bias_q;
        for (int c = 0; c < N_CH; c++) begin
            for (int t = 0; t < K; t++) begin
                if (cfg_we && (cfg_addr == AW'(c * K + t))) begin
                    weight_d[c][t] = cfg_data;
                end
            end
        end
        if (cfg_we && (cfg_addr == AW'(N_CH * K))) begin
            bias_d = cfg_data;
        end
    end

    // S2 adder tree input: sum of the registered tap products.
    always_comb begin
        prod_sum = '0;
        for (int i = 0; i < K; i++) begin
            prod_sum = prod_sum + ACC_W'($signed(prod_q[i]));
        end
    end

    // Finalise: bias, optional ReLU, then clamp to the output range.
    always_comb begin
        fin_sum  = RW'(acc_q) + RW'(bias_q);
        fin_relu = fin_sum;
        if ((RELU_EN != 0) && (fin_sum < 0)) begin
            fin_relu = '0;
        end
        fin_data = fin_relu[BIT_WIDTH-1:0];
        fin_sat  = 1'b0;
        if (fin_relu > SAT_MAX) begin
            fin_data = SAT_MAX[BIT_WIDTH-1:0];
            fin_sat  = 1'b1;
        end else if (fin_relu < SAT_MIN) begin
            fin_data = SAT_MIN[BIT_WIDTH-1:0];
            fin_sat  = 1'b1;
        end
    end

    // Frame sequencing: accumulate N_CH beats, drain the pipeline, hold the result.
    always_comb begin
        state_d     = state_q;
        ch_cnt_d    = ch_cnt_q;
        s1_valid_d  = accept;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;

        if (s1_valid_q) begin
            acc_d = acc_q + prod_sum;
        end

        case (state_q)
            ST_ACCUM: begin
                if (accept) begin
                    if (ch_cnt_q == CH_LAST) begin
                        state_d = ST_DRAIN;
                    end else begin
                        ch_cnt_d = ch_cnt_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                // Once S1 is empty the accumulator holds every channel.
                if (!s1_valid_q) begin
                    state_d     = ST_OUT;
                    out_valid_d = 1'b1;
                    out_data_d  = fin_data;
                    out_sat_d   = fin_sat;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    state_d     = ST_ACCUM;
                    ch_cnt_d    = '0;
                    acc_d       = '0;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_ACCUM;
            end
        endcase
    end

    // State, pipeline and configuration registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= ST_ACCUM;
            ch_cnt_q    <= '0;
            s1_valid_q  <= 1'b0;
            prod_q      <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            bias_q      <= '0;
            for (int c = 0; c < N_CH; c++) begin
                for (int t = 0; t < K; t++) begin
                    weight_q[c][t] <= '0;
                end
            end
        end else begin
            state_q     <= state_d;
            ch_cnt_q    <= ch_cnt_d;
            s1_valid_q  <= s1_valid_d;
            prod_q      <= prod_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            bias_q      <= bias_d;
            weight_q    <= weight_d;
        end
    end

endmodule

// File: tb/tb_conv2d_window_mac_multich.sv
// Bench for conv2d_window_mac_multich: two instances (ReLU on / off) share
// one stimulus stream and are checked against an arithmetic reference model.
module tb_conv2d_window_mac_multich;
    localparam int FILT_DIM = 3;
    localparam int BW       = 16;
    localparam int NFRAC    = 10;
    localparam int N_CH     = 4;
    localparam int K        = FILT_DIM * FILT_DIM;
    localparam int NW       = N_CH * K;
    localparam int AW       = $clog2(NW + 1);
    localparam longint SCALE = longint'(1) << NFRAC;

    logic                 clock = 1'b0;
    logic                 reset = 1'b0;
    logic                 cfg_we = 1'b0;
    logic [AW-1:0]        cfg_addr = '0;
    logic signed [BW-1:0] cfg_data = '0;
    logic                 in_valid = 1'b0;
    logic [K*BW-1:0]      in_window = '0;
    logic                 out_ready = 1'b1;

    logic                 in_ready_r, out_valid_r, out_sat_r;
    logic signed [BW-1:0] out_data_r;
    logic                 in_ready_l, out_valid_l, out_sat_l;
    logic signed [BW-1:0] out_data_l;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int w_m [N_CH][K];
    int bias_m;
    int win_m [N_CH][K];
    int exp_r, exp_l;
    bit exp_sat_r, exp_sat_l;

    always #5 clock = ~clock;

    conv2d_window_mac_multich #(
        .FILT_DIM(FILT_DIM), .BIT_WIDTH(BW), .NFRAC(NFRAC), .N_CH(N_CH), .RELU_EN(1)
    ) u_dut_relu (
        .clock(clock), .reset(reset),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .in_valid(in_valid), .in_ready(in_ready_r), .in_window(in_window),
        .out_valid(out_valid_r), .out_ready(out_ready),
        .out_data(out_data_r), .out_sat(out_sat_r)
    );

    conv2d_window_mac_multich #(
        .FILT_DIM(FILT_DIM), .BIT_WIDTH(BW), .NFRAC(NFRAC), .N_CH(N_CH), .RELU_EN(0)
    ) u_dut_lin (
        .clock(clock), .reset(reset),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .in_valid(in_valid), .in_ready(in_ready_l), .in_window(in_window),
        .out_valid(out_valid_l), .out_ready(out_ready),
        .out_data(out_data_l), .out_sat(out_sat_l)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] req);
        n_checks++;
        assert (obs === req) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, req);
        end
    endtask

    // Fixed-point product rescale: floor(p / 2^NFRAC).
    function automatic longint floor_q(input longint p);
        longint q;
        q = p / SCALE;
        if (p < 0 && q * SCALE != p) q = q - 1;
        return q;
    endfunction

    task automatic finish_model(input longint acc, input bit relu, output int data, output bit sat);
        longint r;
        r = acc + longint'(bias_m);
        sat = 1'b0;
        if (relu && r < 0) r = 0;
        if (r > 32767) begin
            r = 32767; sat = 1'b1;
        end else if (r < -32768) begin
            r = -32768; sat = 1'b1;
        end
        data = int'(r);
    endtask

    task automatic model_cfg(input int addr, input int data);
        if (addr < NW) w_m[addr / K][addr % K] = data;
        else if (addr == NW) bias_m = data;
    endtask

    task automatic model_clear();
        for (int c = 0; c < N_CH; c++)
            for (int t = 0; t < K; t++) w_m[c][t] = 0;
        bias_m = 0;
    endtask

    // All tasks start and end just after a falling edge.
    task automatic do_reset();
        reset = 1'b0; in_valid = 1'b0; cfg_we = 1'b0;
        @(posedge clock); @(negedge clock);
        reset = 1'b1;
        model_clear();
    endtask

    task automatic cfg_write(input int addr, input int data);
        cfg_we = 1'b1; cfg_addr = AW'(addr); cfg_data = BW'(data);
        @(posedge clock); @(negedge clock);
        cfg_we = 1'b0;
        model_cfg(addr, data);
    endtask

    task automatic write_weights_const(input int v);
        for (int a = 0; a < NW; a++) cfg_write(a, v);
    endtask

    task automatic set_frame_const(input int v);
        for (int c = 0; c < N_CH; c++)
            for (int t = 0; t < K; t++) win_m[c][t] = v;
    endtask

    task automatic drive_beat(input int c);
        logic [K*BW-1:0] win;
        for (int t = 0; t < K; t++) win[t*BW +: BW] = BW'(win_m[c][t]);
        in_window = win;
        in_valid  = 1'b1;
    endtask

    // Sends one frame, optionally with a config write on beat cw_beat, then
    // checks the 3-cycle result latency and the result of both instances.
    task automatic send_frame(input string tag, input int gap, input int cw_beat,
                              input int cw_addr, input int cw_data);
        longint acc;
        acc = 0;
        for (int c = 0; c < N_CH; c++) begin
            drive_beat(c);
            if (c == cw_beat) begin
                cfg_we = 1'b1; cfg_addr = AW'(cw_addr); cfg_data = BW'(cw_data);
            end
            chk({tag, " in_ready"}, 32'(in_ready_r), 1);
            for (int t = 0; t < K; t++)
                acc += floor_q(longint'(w_m[c][t]) * longint'(win_m[c][t]));
            if (c == cw_beat) model_cfg(cw_addr, cw_data);
            @(posedge clock); @(negedge clock);
            in_valid = 1'b0; cfg_we = 1'b0;
            if (c != N_CH - 1) repeat (gap) @(negedge clock);
        end
        chk({tag, " lat+1 valid"}, 32'(out_valid_r), 0);
        @(negedge clock);
        chk({tag, " lat+2 valid"}, 32'(out_valid_l), 0);
        @(negedge clock);
        finish_model(acc, 1'b1, exp_r, exp_sat_r);
        finish_model(acc, 1'b0, exp_l, exp_sat_l);
        chk({tag, " valid relu"}, 32'(out_valid_r), 1);
        chk({tag, " valid lin"},  32'(out_valid_l), 1);
        chk({tag, " data relu"},  out_data_r, exp_r);
        chk({tag, " sat relu"},   32'(out_sat_r), 32'(exp_sat_r));
        chk({tag, " data lin"},   out_data_l, exp_l);
        chk({tag, " sat lin"},    32'(out_sat_l), 32'(exp_sat_l));
        $display("frame %s: relu=%0d sat=%0d lin=%0d sat=%0d", tag, out_data_r, out_sat_r, out_data_l, out_sat_l);
    endtask

    // After a frame with out_ready high: handshake completes, result held.
    task automatic post_handshake(input string tag);
        @(negedge clock);
        chk({tag, " post valid"}, 32'(out_valid_r), 0);
        chk({tag, " post ready"}, 32'(in_ready_l), 1);
        chk({tag, " post hold"},  out_data_l, exp_l);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clock);
        do_reset();
        chk("reset out_valid", 32'(out_valid_r), 0);
        chk("reset out_data",  out_data_l, 0);
        chk("reset out_sat",   32'(out_sat_l), 0);
        chk("reset in_ready",  32'(in_ready_r), 1);

        // Nominal: 0.5 weights, 1.0 taps, bias 0.25 -> 18.25
        write_weights_const(512);
        cfg_write(NW, 256);
        cfg_write(40, 999);              // out-of-range address, ignored
        set_frame_const(1024);
        out_ready = 1'b1;
        send_frame("nominal", 0, -1, 0, 0);
        chk("nominal const", out_data_r, 18688);
        post_handshake("nominal");

        // Backpressure: result held while out_ready low
        out_ready = 1'b0;
        send_frame("bp", 0, -1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("bp hold valid", 32'(out_valid_r), 1);
            chk("bp hold data",  out_data_r, 18688);
            chk("bp in_ready",   32'(in_ready_l), 0);
        end
        out_ready = 1'b1;
        post_handshake("bp");
        send_frame("bp next", 0, -1, 0, 0);
        post_handshake("bp next");

        // Bubbles between beats
        send_frame("bubble", 2, -1, 0, 0);
        chk("bubble const", out_data_l, 18688);
        post_handshake("bubble");

        // Saturation both directions
        write_weights_const(1024);
        send_frame("sat pos", 0, -1, 0, 0);
        chk("sat pos const", out_data_l, 32767);
        post_handshake("sat pos");
        write_weights_const(-1024);
        send_frame("sat neg", 1, -1, 0, 0);
        chk("sat neg lin",  out_data_l, -32768);
        chk("sat neg relu", out_data_r, 0);
        post_handshake("sat neg");

        // Randomized frames against the model
        for (int n = 0; n < 6; n++) begin
            for (int a = 0; a < NW; a++) cfg_write(a, int'($urandom_range(0, 2047)) - 1024);
            cfg_write(NW, int'($urandom_range(0, 16383)) - 8192);
            for (int c = 0; c < N_CH; c++)
                for (int t = 0; t < K; t++) win_m[c][t] = int'($urandom_range(0, 4095)) - 2048;
            send_frame("random", int'($urandom_range(0, 2)), -1, 0, 0);
            post_handshake("random");
        end

        // Reset mid-frame discards the partial sum and configuration
        set_frame_const(1024);
        for (int c = 0; c < 2; c++) begin
            drive_beat(c);
            @(posedge clock); @(negedge clock);
        end
        in_valid = 1'b0;
        do_reset();
        chk("midrst out_valid", 32'(out_valid_l), 0);
        chk("midrst out_data",  out_data_r, 0);
        chk("midrst out_sat",   32'(out_sat_r), 0);
        chk("midrst in_ready",  32'(in_ready_r), 1);
        send_frame("after reset", 0, -1, 0, 0);
        chk("after reset const", out_data_l, 0);
        post_handshake("after reset");

        // Floor rounding and same-cycle config write
        do_reset();
        cfg_write(0, 1);
        set_frame_const(0);
        win_m[0][0] = -1;
        win_m[1][0] = 1024;
        send_frame("round", 0, 1, K, 1024);
        chk("round lin const",  out_data_l, -1);
        chk("round relu const", out_data_r, 0);
        post_handshake("round");
        send_frame("round next", 0, -1, 0, 0);
        chk("round next const", out_data_l, 1023);
        post_handshake("round next");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
